mul_unit: RTL and testbench
===========================

Name: mul_unit

Overview:
- Iterative multi-cycle RV32M multiplier in the EX stage.
- Consumes the EX controller's `mulctl` encoding and operands. Returns the 32-bit result, plus the `mulvalid` handshake that the controller uses with `ifuresctl` to select the multiplier result.
- Radix-2 shift-add on operand magnitudes with final sign correction. Latency is fixed and independent of the data.

Parameters:
- XLEN, 32, operand/result width. The product register is 2*XLEN; the step counter is $clog2(XLEN) bits.

Ports:
- clk  input  1  system clock; all state updates on the rising edge
- rst  input  1  synchronous, active-high reset
- mulctl  input  2  00=mul (low word), 01=mulh (s×s high), 10=mulhsu (rs1 signed × rs2 unsigned, high), 11=mulhu (u×u high)
- rs1  input  XLEN  multiplicand operand
- rs2  input  XLEN  multiplier operand
- start  input  1  request; accepted only when mul_ready=1
- flush  input  1  pipeline kill; aborts any operation in flight
- mul_ack  input  1  consumer accepts the result
- mul_ready  output  1  unit idle and able to accept start
- mulvalid  output  1  result valid, held until acknowledged
- mulres  output  XLEN  result

Behaviour:
- Reset (rst=1 at an edge):
  - state=IDLE, mul_ready=1, mulvalid=0, mulres=0, counter=0, product=0.
  - Reset overrides start, flush and mul_ack, including mid-operation.
- FSM states: IDLE, BUSY, DONE.
- mul_ready = (state==IDLE), decoded from the state register (no combinational path from start).
- IDLE, on an edge with start=1 and flush=0 (acceptance edge E0):
  - Latch mulctl.
  - Latch |rs1| if rs1 is signed (mulctl 01/10) and rs1[XLEN-1]=1; otherwise latch rs1 raw.
  - Latch |rs2| if rs2 is signed (mulctl 01 only) and rs2[XLEN-1]=1; otherwise latch rs2 raw.
  - neg = sign(rs1 used) XOR sign(rs2 used).
  - product=0, counter=0, go to BUSY.
  - start with flush=1 in the same cycle is ignored.
- BUSY, one step per edge:
  - If multiplier bit[counter]=1, add the multiplicand, shifted by counter, into the 2*XLEN product.
  - counter increments each step.
  - Exactly XLEN steps (edges E1..EXLEN); no early termination on zero operands.
- Step EXLEN, i.e. counter==XLEN-1:
  - Final = neg ? (~product+1) : product, computed in 2*XLEN bits.
  - mulres = (mulctl==00) ? final[XLEN-1:0] : final[2*XLEN-1:XLEN].
  - mulvalid=1, go to DONE.
  - mulvalid is first visible in the cycle after edge E32 (XLEN=32), i.e. 32 edges after the acceptance edge.
- DONE:
  - mulvalid and mulres are held stable while mul_ack=0 (back-pressure, no limit).
  - On an edge with mul_ack=1: mulvalid=0, go to IDLE; mul_ready=1 in the next cycle.
  - mulres keeps its last value (don't-care after mulvalid falls).
  - start is ignored in DONE, even when it coincides with mul_ack; no same-cycle back-to-back.
- Signed corner cases:
  - |−2^(XLEN-1)| = 2^(XLEN-1), represented exactly in XLEN unsigned bits.
  - A 2*XLEN product cannot overflow.
- Flush:
  - In BUSY or DONE, flush=1 at an edge → IDLE, mulvalid=0. The partial product is discarded and no mulvalid pulse is produced.
  - Flush outranks mul_ack.
  - Flush in IDLE has no effect.
- Priority at an edge: rst > flush > state logic.

Test Plan:
- mulctl=00, rs1=7, rs2=0xFFFFFFFD (−3) → mulres=0xFFFFFFEB. mulvalid rises 32 edges after acceptance; mul_ready=0 throughout BUSY/DONE.
- mulctl=01, rs1=rs2=0x80000000 → mulres=0x40000000. Also mulctl=01, rs1=0xFFFFFFFF, rs2=2 → mulres=0xFFFFFFFF.
- mulctl=10, rs1=0xFFFFFFFF, rs2=0xFFFFFFFF → mulres=0xFFFFFFFF (product 0xFFFFFFFF_00000001). Also mulctl=11 with the same operands → mulres=0xFFFFFFFE.
- Back-pressure: hold mul_ack=0 for 5 cycles after mulvalid → mulvalid=1 and mulres constant all 5 cycles. Pulsing start during this window is ignored. mul_ack=1 → mulvalid=0 and mul_ready=1 the next cycle.
- Flush at 10th BUSY cycle → mulvalid never asserts, mul_ready=1 next cycle. A new mulctl=11 request with rs1=3, rs2=5 then gives mulres=0 after the full latency, and a subsequent mulctl=00 request with rs1=3, rs2=5 gives mulres=15.
- rst asserted mid-BUSY and separately in DONE with mul_ack=1 → all outputs at reset values next cycle (mul_ready=1, mulvalid=0, mulres=0). A zero-operand request afterwards still takes the full 32-edge latency and yields 0.

Source files
------------

// File: rtl/mul_unit.sv
// Iterative RV32M multiplier: radix-2 shift-add on operand magnitudes with a
// final sign correction; fixed XLEN-step latency and a valid/ack result handshake.
module mul_unit #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [1:0]      mulctl,
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] rs2,
  input  logic            start,
  input  logic            flush,
  input  logic            mul_ack,
  output logic            mul_ready,
  output logic            mulvalid,
  output logic [XLEN-1:0] mulres
);

  localparam int CW = $clog2(XLEN);
  localparam int PW = 2 * XLEN;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t          state_q, state_d;
  logic [1:0]      ctl_q, ctl_d;
  logic [XLEN-1:0] mcand_q, mcand_d;
  logic [XLEN-1:0] mplier_q, mplier_d;
  logic            neg_q, neg_d;
  logic [PW-1:0]   product_q, product_d;
  logic [CW-1:0]   count_q, count_d;
  logic [XLEN-1:0] res_q, res_d;
  logic            valid_q, valid_d;

  logic            rs1_neg, rs2_neg;
  logic [PW-1:0]   addend, step_sum, final_prod;

  // rs1 is signed for mulh/mulhsu, rs2 only for mulh; mul's low word needs no sign handling.
  always_comb begin
    rs1_neg    = ((mulctl == 2'b01) || (mulctl == 2'b10)) && rs1[XLEN-1];
    rs2_neg    = (mulctl == 2'b01) && rs2[XLEN-1];
    addend     = mplier_q[count_q] ? ({{XLEN{1'b0}}, mcand_q} << count_q) : '0;
    step_sum   = product_q + addend;
    final_prod = neg_q ? (~step_sum + PW'(1)) : step_sum;

    state_d   = state_q;
    ctl_d     = ctl_q;
    mcand_d   = mcand_q;
    mplier_d  = mplier_q;
    neg_d     = neg_q;
    product_d = product_q;
    count_d   = count_q;
    res_d     = res_q;
    valid_d   = valid_q;

    case (state_q)
      IDLE: begin
        if (start && !flush) begin
          ctl_d     = mulctl;
          mcand_d   = rs1_neg ? (~rs1 + XLEN'(1)) : rs1;
          mplier_d  = rs2_neg ? (~rs2 + XLEN'(1)) : rs2;
          neg_d     = rs1_neg ^ rs2_neg;
          product_d = '0;
          count_d   = '0;
          state_d   = BUSY;
        end
      end
      BUSY: begin
        if (flush) begin
          valid_d = 1'b0;
          state_d = IDLE;
        end else begin
          product_d = step_sum;
          count_d   = count_q + CW'(1);
          // The last step folds its own partial product straight into the result.
          if (count_q == CW'(XLEN - 1)) begin
            res_d   = (ctl_q == 2'b00) ? final_prod[XLEN-1:0] : final_prod[PW-1:XLEN];
            valid_d = 1'b1;
            state_d = DONE;
          end
        end
      end
      DONE: begin
        if (flush || mul_ack) begin
          valid_d = 1'b0;
          state_d = IDLE;
        end
      end
      default: begin
        valid_d = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      ctl_q     <= '0;
      mcand_q   <= '0;
      mplier_q  <= '0;
      neg_q     <= 1'b0;
      product_q <= '0;
      count_q   <= '0;
      res_q     <= '0;
      valid_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      ctl_q     <= ctl_d;
      mcand_q   <= mcand_d;
      mplier_q  <= mplier_d;
      neg_q     <= neg_d;
      product_q <= product_d;
      count_q   <= count_d;
      res_q     <= res_d;
      valid_q   <= valid_d;
    end
  end

  assign mul_ready = (state_q == IDLE);
  assign mulvalid  = valid_q;
  assign mulres    = res_q;

endmodule

// File: tb/tb_mul_unit.sv
// Self-checking bench for mul_unit: 64-bit arithmetic reference plus a latency
// model, directed corner cases and randomized requests.
module tb_mul_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  mulctl = 2'b00;
  logic [31:0] rs1 = '0;
  logic [31:0] rs2 = '0;
  logic        start = 1'b0;
  logic        flush = 1'b0;
  logic        mul_ack = 1'b0;
  logic        mul_ready, mulvalid;
  logic [31:0] mulres;

  int checks = 0;
  int errors = 0;

  mul_unit #(.XLEN(32)) dut (
    .clk(clk), .rst(rst), .mulctl(mulctl), .rs1(rs1), .rs2(rs2),
    .start(start), .flush(flush), .mul_ack(mul_ack),
    .mul_ready(mul_ready), .mulvalid(mulvalid), .mulres(mulres)
  );

  always #5 clk = ~clk;

  // Architectural result: sign/zero-extend to 64 bits and multiply.
  function automatic logic [31:0] ref_mul(input logic [1:0] ctl, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] ea, eb, p;
    ea = ((ctl == 2'b01) || (ctl == 2'b10)) ? {{32{a[31]}}, a} : {32'b0, a};
    eb = (ctl == 2'b01) ? {{32{b[31]}}, b} : {32'b0, b};
    p  = ea * eb;
    return (ctl == 2'b00) ? p[31:0] : p[63:32];
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, actual, expected, $time);
    end
  endtask

  // Transaction-level model: idle / busy for 32 edges / done until acked.
  int          m_state = 0;
  int          m_left = 0;
  bit          m_valid = 1'b0;
  bit          m_init = 1'b0;
  logic [31:0] m_res = '0;
  logic [31:0] m_pend = '0;

  always @(posedge clk) begin
    if (rst) begin
      m_state = 0; m_valid = 1'b0; m_res = '0; m_init = 1'b1;
    end else if (flush && m_state != 0) begin
      m_state = 0; m_valid = 1'b0;
    end else begin
      case (m_state)
        0: if (start && !flush) begin
          m_state = 1; m_left = 32; m_pend = ref_mul(mulctl, rs1, rs2);
        end
        1: begin
          m_left--;
          if (m_left == 0) begin
            m_state = 2; m_valid = 1'b1; m_res = m_pend;
          end
        end
        default: if (mul_ack) begin
          m_state = 0; m_valid = 1'b0;
        end
      endcase
    end
  end

  always @(negedge clk) begin
    if (m_init) begin
      checkOutput("model_ready", {31'b0, mul_ready}, {31'b0, m_state == 0});
      checkOutput("model_valid", {31'b0, mulvalid}, {31'b0, m_valid});
      if (m_valid) checkOutput("model_res", mulres, m_res);
    end
  end

  // Issue one request, wait (bounded) for the result, hold back-pressure, then ack.
  task automatic applyStimulus(input logic [1:0] ctl, input logic [31:0] a, input logic [31:0] b,
                               input int ack_delay, input bit pulse_start,
                               output logic [31:0] res, output int edges);
    @(negedge clk);
    mulctl = ctl; rs1 = a; rs2 = b; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0; rs1 = $urandom; rs2 = $urandom; mulctl = 2'($urandom);
    edges = 0;
    res = 'x;
    while (edges < 100) begin
      @(posedge clk); edges++; #1;
      if (mulvalid) break;
    end
    if (!mulvalid) begin
      checkOutput("result_timeout", 32'd0, 32'd1);
      return;
    end
    res = mulres;
    for (int i = 0; i < ack_delay; i++) begin
      @(negedge clk); start = pulse_start;
      @(posedge clk); #1;
      checkOutput("hold_valid", {31'b0, mulvalid}, 32'd1);
      checkOutput("hold_res", mulres, res);
    end
    @(negedge clk); mul_ack = 1'b1; start = pulse_start;
    @(posedge clk); #1;
    checkOutput("ack_ready", {31'b0, mul_ready}, 32'd1);
    checkOutput("ack_valid", {31'b0, mulvalid}, 32'd0);
    @(negedge clk); mul_ack = 1'b0; start = 1'b0;
  endtask

  task automatic waitValid(output bit seen);
    seen = 1'b0;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(posedge clk); #1;
      seen = mulvalid;
    end
  endtask

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, "_ready"}, {31'b0, mul_ready}, 32'd1);
    checkOutput({tag, "_valid"}, {31'b0, mulvalid}, 32'd0);
    checkOutput({tag, "_res"}, mulres, 32'd0);
  endtask

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [31:0] res;
    int edges;
    bit seen;
    logic [31:0] a, b;
    logic [1:0] ctl;

    repeat (2) @(posedge clk);
    #1;
    checkResetOutputs("reset");
    @(negedge clk); rst = 1'b0;

    applyStimulus(2'b00, 32'd7, 32'hFFFFFFFD, 0, 1'b0, res, edges);
    checkOutput("mul_7_neg3", res, 32'hFFFFFFEB);
    checkOutput("latency", edges, 32'd32);
    applyStimulus(2'b01, 32'h80000000, 32'h80000000, 0, 1'b0, res, edges);
    checkOutput("mulh_min_min", res, 32'h40000000);
    applyStimulus(2'b01, 32'hFFFFFFFF, 32'd2, 1, 1'b0, res, edges);
    checkOutput("mulh_neg1_2", res, 32'hFFFFFFFF);
    applyStimulus(2'b10, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, 1'b0, res, edges);
    checkOutput("mulhsu_ones", res, 32'hFFFFFFFF);
    applyStimulus(2'b11, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, 1'b0, res, edges);
    checkOutput("mulhu_ones", res, 32'hFFFFFFFE);

    // Back-pressure with start pulses that must be ignored, including on the ack edge.
    applyStimulus(2'b00, 32'd1234, 32'd5678, 5, 1'b1, res, edges);
    checkOutput("backpressure_res", res, 32'd7006652);

    // Start together with flush in IDLE is dropped.
    @(negedge clk); start = 1'b1; flush = 1'b1;
    @(posedge clk); #1;
    checkOutput("idle_flush_ready", {31'b0, mul_ready}, 32'd1);
    @(negedge clk); start = 1'b0; flush = 1'b0;

    // Flush on the 10th busy edge.
    @(negedge clk); mulctl = 2'b00; rs1 = 32'hDEADBEEF; rs2 = 32'h12345678; start = 1'b1;
    @(posedge clk);
    @(negedge clk); start = 1'b0;
    repeat (9) @(negedge clk);
    flush = 1'b1;
    @(posedge clk); #1;
    checkOutput("flush_ready", {31'b0, mul_ready}, 32'd1);
    checkOutput("flush_valid", {31'b0, mulvalid}, 32'd0);
    @(negedge clk); flush = 1'b0;
    seen = 1'b0;
    repeat (40) begin
      @(posedge clk); #1;
      if (mulvalid) seen = 1'b1;
    end
    checkOutput("flush_no_valid", {31'b0, seen}, 32'd0);
    applyStimulus(2'b11, 32'd3, 32'd5, 0, 1'b0, res, edges);
    checkOutput("mulhu_3_5", res, 32'd0);
    checkOutput("mulhu_latency", edges, 32'd32);
    applyStimulus(2'b00, 32'd3, 32'd5, 0, 1'b0, res, edges);
    checkOutput("mul_3_5", res, 32'd15);

    // Reset mid-busy.
    @(negedge clk); mulctl = 2'b01; rs1 = 32'h7FFFFFFF; rs2 = 32'h80000001; start = 1'b1;
    @(posedge clk);
    @(negedge clk); start = 1'b0;
    repeat (14) @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    checkResetOutputs("rst_busy");
    @(negedge clk); rst = 1'b0;

    // Reset in DONE while acknowledging.
    @(negedge clk); mulctl = 2'b11; rs1 = 32'hFFFF0000; rs2 = 32'h0000FFFF; start = 1'b1;
    @(posedge clk);
    @(negedge clk); start = 1'b0;
    waitValid(seen);
    checkOutput("rst_done_reach", {31'b0, seen}, 32'd1);
    @(negedge clk); rst = 1'b1; mul_ack = 1'b1;
    @(posedge clk); #1;
    checkResetOutputs("rst_done");
    @(negedge clk); rst = 1'b0; mul_ack = 1'b0;

    applyStimulus(2'b01, 32'd0, 32'd0, 0, 1'b0, res, edges);
    checkOutput("zero_res", res, 32'd0);
    checkOutput("zero_latency", edges, 32'd32);

    for (int n = 0; n < 40; n++) begin
      ctl = 2'($urandom_range(0, 3));
      case ($urandom_range(0, 3))
        0: a = 32'h80000000;
        1: a = 32'hFFFFFFFF;
        default: a = $urandom;
      endcase
      case ($urandom_range(0, 3))
        0: b = 32'h80000000;
        1: b = 32'd0;
        default: b = $urandom;
      endcase
      applyStimulus(ctl, a, b, $urandom_range(0, 3), 1'($urandom_range(0, 1)), res, edges);
      checkOutput("rand_res", res, ref_mul(ctl, a, b));
      checkOutput("rand_latency", edges, 32'd32);
    end

    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
